board_mem_reader: RTL and testbench

BOARD_MEM_READER -- requirements
Module: board_mem_reader

---
 rtl/board_mem_reader_pkg.sv | 28 ++
 rtl/board_mem_reader_if.sv | 16 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/board_mem_reader.sv | 139 +++++++++++++
 tb/tb_board_mem_reader.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_mem_reader_pkg.sv
// Shared types and constants for the board memory reader.
// FSM encoding, hex glyph table and default parameter values.
package board_mem_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [31:0] DEF_SCAN_PERIOD = 32'd50000000;
  localparam logic [15:0] DEF_REFRESH_DIV = 16'd50000;
  localparam int DEF_READ_LATENCY = 1;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost slice.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    return HEX_SEG[v];
  endfunction

endpackage

// File: rtl/board_mem_reader_if.sv
// CPU debug-port read bus between the reader and memory.
// The reader drives the address; memory returns the word.
interface board_mem_reader_if;
  logic [5:0]  board_mem_read_addr;
  logic [31:0] board_mem_read_result;

  modport master (
    output board_mem_read_addr,
    input  board_mem_read_result
  );

  modport slave (
    input  board_mem_read_addr,
    output board_mem_read_result
  );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, stable-level counter,
// single-cycle pulse on an accepted rising level.
module btn_debounce #(
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  logic        s1;
  logic        s2;
  logic        level;
  logic [15:0] cnt;
  logic        accept;

  assign accept = ({1'b0, cnt} + 17'd1) >= {1'b0, CYCLES};

  // Sync, count cycles the new level persists, accept and pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
        rise  <= s2;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/board_mem_reader.sv
// Steps a 6-bit debug address, captures the word read back
// and shows half of it on a multiplexed 4-digit display.
module board_mem_reader
  import board_mem_reader_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [31:0] SCAN_PERIOD = DEF_SCAN_PERIOD,
  parameter logic [15:0] REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        auto_scan,
  input  logic        half_sel,
  board_mem_reader_if.master bus,
  output logic [31:0] shown_word,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam logic [1:0] LAT = 2'(READ_LATENCY);
  localparam state_t FIRST = (LAT == 2'd0) ? ST_CAPTURE : ST_WAIT;

  logic        nx_p;
  logic        pv_p;
  logic [31:0] scan_cnt;
  logic        scan_tick;
  logic        step_v;
  logic [5:0]  step_d;
  state_t      state;
  logic [1:0]  wait_cnt;
  logic        pend_v;
  logic [5:0]  pend_d;
  logic [5:0]  addr;
  logic [15:0] ref_cnt;
  logic [1:0]  dig;
  logic [1:0]  dig_nx;
  logic [15:0] half;
  logic [3:0]  nib;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_next),
    .rise (nx_p)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_prev),
    .rise (pv_p)
  );

  assign scan_tick = auto_scan &&
    ((scan_cnt + 32'd1) >= SCAN_PERIOD);

  // Both buttons together cancel; the tick only fills an empty cycle.
  assign step_v = (nx_p ^ pv_p) | (~nx_p & ~pv_p & scan_tick);
  assign step_d = (nx_p | (~pv_p & scan_tick)) ? 6'd1 : 6'h3F;

  assign bus.board_mem_read_addr = addr;

  // Scan timer runs only while scanning and restarts on any step.
  always_ff @(posedge clk) begin
    if (!rst_n || !auto_scan || step_v) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 32'd1;
    end
  end

  // Read sequencer with a one-deep pending step; boots with a read of 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      pend_v     <= 1'b1;
      pend_d     <= '0;
      addr       <= '0;
      shown_word <= '0;
    end else begin
      if (state != ST_IDLE && step_v && !pend_v) begin
        pend_v <= 1'b1;
        pend_d <= step_d;
      end
      unique case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (pend_v) begin
            addr   <= addr + pend_d;
            pend_v <= step_v;
            pend_d <= step_d;
            state  <= FIRST;
          end else if (step_v) begin
            addr  <= addr + step_d;
            state <= FIRST;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LAT - 2'd1) begin
            state <= ST_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_CAPTURE: begin
          shown_word <= bus.board_mem_read_result;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dig_nx = dig + 2'd1;
  assign half = half_sel ? shown_word[31:16] : shown_word[15:0];
  assign nib = half[{dig_nx, 2'b00} +: 4];

  // Digit multiplexer; glyph and enable change only at refresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      dig     <= '0;
      an      <= 4'b1110;
      seg     <= hex_seg(4'h0);
    end else if (({1'b0, ref_cnt} + 17'd1) >= {1'b0, REFRESH_DIV}) begin
      ref_cnt <= '0;
      dig     <= dig_nx;
      an      <= ~(4'b0001 << dig_nx);
      seg     <= hex_seg(nib);
    end else begin
      ref_cnt <= ref_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_board_mem_reader.sv
// Directed bench for board_mem_reader with a word-level
// memory model and a per-cycle compare process.
module tb_board_mem_reader;

  localparam int DIV = 2;

  logic        clk;
  logic        rst_n;
  logic        btn_next;
  logic        btn_prev;
  logic        auto_scan;
  logic        half_sel;
  logic [31:0] shown_word;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic [31:0] mem [64];
  logic [5:0]  exp_addr;
  logic [31:0] exp_shown;
  bit          chk_en;
  int          checks;
  int          errors;

  board_mem_reader_if bus ();

  board_mem_reader #(
    .DEBOUNCE_CYCLES(16'd4),
    .SCAN_PERIOD(32'd10),
    .REFRESH_DIV(16'(DIV)),
    .READ_LATENCY(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .auto_scan (auto_scan),
    .half_sel  (half_sel),
    .bus       (bus),
    .shown_word(shown_word),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency memory.
  always @(posedge clk)
    bus.board_mem_read_result <= mem[bus.board_mem_read_addr];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, got, want, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79;
      4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12;
      4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10;
      4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21;
      4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic int digit_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++)
      if (!a[i]) return i;
    return 0;
  endfunction

  // Per-cycle compare against the model.
  initial begin : compare
    logic [3:0]  prev_an;
    logic [3:0]  want_an;
    logic [15:0] h;
    logic        prev_half;
    logic [31:0] prev_shown;
    bit          prev_en;
    bit          seen;
    int          run;
    int          age;
    int          k;
    prev_an = 4'b1110;
    prev_half = 1'b0;
    prev_shown = '0;
    prev_en = 0;
    seen = 0;
    run = 0;
    age = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_an = 4'b1110;
        seen = 0;
        run = 0;
        age = 0;
        prev_en = 0;
        continue;
      end
      if (chk_en) begin
        check("addr", 32'(bus.board_mem_read_addr), 32'(exp_addr));
        check("shown", shown_word, exp_shown);
      end
      check("an_onehot", 32'($countones(~an)), 32'd1);
      if (an != prev_an) begin
        if (seen) check("an_dwell", 32'(run), 32'(DIV));
        want_an = ~(4'b0001 << ((digit_of(prev_an) + 1) % 4));
        check("an_order", 32'(an), 32'(want_an));
        seen = 1;
        run = 1;
      end else begin
        run++;
      end
      prev_an = an;
      if (chk_en && prev_en && half_sel == prev_half &&
          exp_shown == prev_shown)
        age++;
      else
        age = 0;
      prev_en = chk_en;
      prev_half = half_sel;
      prev_shown = exp_shown;
      if (age > 2 * DIV + 1) begin
        h = half_sel ? exp_shown[31:16] : exp_shown[15:0];
        k = digit_of(an);
        check("seg", 32'(seg), 32'(glyph(h[4*k +: 4])));
      end
    end
  end

  task automatic press(input logic nx, input logic pv);
    btn_next = nx;
    btn_prev = pv;
    repeat (8) @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic expect_move(input logic [5:0] d);
    exp_addr = exp_addr + d;
    exp_shown = mem[exp_addr];
    chk_en = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_an(input int k, input logic [6:0] want,
                         input string name);
    logic [3:0] target;
    bit found;
    target = ~(4'b0001 << k);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (an == target) found = 1;
    end
    check({name, "_found"}, 32'(found), 32'd1);
    check(name, 32'(seg), 32'(want));
  endtask

  initial begin : stim
    logic [6:0] lo [4];
    logic [6:0] hi [4];
    bit found;
    lo = '{7'h00, 7'h78, 7'h02, 7'h12};
    hi = '{7'h19, 7'h30, 7'h24, 7'h79};
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++)
      mem[i] = {16'hCAFE, 10'd0, 6'(i)};
    mem[0] = 32'hDEADBEEF;
    mem[8] = 32'h12345678;
    rst_n = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    auto_scan = 1'b0;
    half_sel = 1'b0;
    chk_en = 0;
    exp_addr = '0;
    exp_shown = '0;

    repeat (3) @(negedge clk);
    check("rst_addr", 32'(bus.board_mem_read_addr), 32'd0);
    check("rst_word", shown_word, 32'd0);
    check("rst_an", 32'(an), 32'hE);
    check("rst_seg", 32'(seg), 32'h40);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("boot_word", shown_word, 32'hDEADBEEF);
    check("boot_addr", 32'(bus.board_mem_read_addr), 32'd0);
    exp_shown = 32'hDEADBEEF;
    chk_en = 1;
    repeat (5) @(negedge clk);

    chk_en = 0;
    btn_next = 1'b1;
    repeat (2) @(negedge clk);
    btn_next = 1'b0;
    repeat (2) @(negedge clk);
    btn_next = 1'b1;
    repeat (8) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    expect_move(6'd1);
    check("bounce_addr", 32'(bus.board_mem_read_addr), 32'd1);
    check("bounce_word", shown_word, 32'hCAFE0001);

    chk_en = 0;
    press(1'b0, 1'b1);
    expect_move(6'h3F);
    chk_en = 0;
    press(1'b0, 1'b1);
    expect_move(6'h3F);
    check("wrap_dn_addr", 32'(bus.board_mem_read_addr), 32'd63);
    check("wrap_dn_word", shown_word, 32'hCAFE003F);
    chk_en = 0;
    press(1'b1, 1'b0);
    expect_move(6'd1);
    check("wrap_up_addr", 32'(bus.board_mem_read_addr), 32'd0);

    mem[0] = 32'h0BADF00D;
    press(1'b1, 1'b1);
    check("both_word", shown_word, 32'hDEADBEEF);

    chk_en = 0;
    btn_prev = 1'b1;
    @(negedge clk);
    btn_next = 1'b1;
    repeat (8) @(negedge clk);
    btn_prev = 1'b0;
    @(negedge clk);
    btn_next = 1'b0;
    repeat (14) @(negedge clk);
    expect_move(6'd0);
    check("pend_word", shown_word, 32'h0BADF00D);

    chk_en = 0;
    repeat (5) press(1'b1, 1'b0);
    expect_move(6'd5);
    chk_en = 0;
    auto_scan = 1'b1;
    repeat (35) @(negedge clk);
    auto_scan = 1'b0;
    repeat (6) @(negedge clk);
    expect_move(6'd3);
    check("scan_addr", 32'(bus.board_mem_read_addr), 32'd8);
    check("scan_word", shown_word, 32'h12345678);
    repeat (25) @(negedge clk);

    repeat (12) @(negedge clk);
    for (int k = 0; k < 4; k++) wait_an(k, lo[k], "seg_lo");
    half_sel = 1'b1;
    repeat (12) @(negedge clk);
    for (int k = 0; k < 4; k++) wait_an(k, hi[k], "seg_hi");
    half_sel = 1'b0;

    chk_en = 0;
    btn_next = 1'b1;
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (bus.board_mem_read_addr == 6'd9) found = 1;
    end
    check("abort_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    btn_next = 1'b0;
    @(posedge clk);
    #1;
    check("abort_word", shown_word, 32'd0);
    check("abort_addr", 32'(bus.board_mem_read_addr), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold", shown_word, 32'd0);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    exp_addr = '0;
    exp_shown = mem[0];
    chk_en = 1;
    repeat (10) @(negedge clk);
    check("reboot_word", shown_word, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
